sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller internal access interface (adr/dat/sel/acc/we/ack) between NUM_PORTS wishbone port instances.
- Sits entirely in the sdram_clk domain, between the wb_port instances' internal-interface side and the SDRAM controller.
- Grants one port at a time. Holds the grant across the short acc gap inside a two-burst refill so a refill is never split by another port.
- Arbitration is round-robin by default.

Parameters:
- NUM_PORTS, 2: number of requesting ports, range 2..8.
- HOLD_CYCLES, 4: cycles the grant is retained after the granted port drops acc; 0 disables hold.

Ports:
- sdram_clk  in  1  controller clock
- sdram_rst_n  in  1  reset, asynchronous, active-low
- port_adr_i  in  NUM_PORTS*32  per-port address, port k at [32k+31:32k]
- port_dat_i  in  NUM_PORTS*16  per-port write data
- port_sel_i  in  NUM_PORTS*2  per-port byte selects
- port_acc_i  in  NUM_PORTS  per-port access request
- port_we_i  in  NUM_PORTS  per-port write enable
- port_ack_o  out  NUM_PORTS  per-port ack, only the granted bit can be set
- port_dat_o  out  16  read data, broadcast to all ports
- adr_o  out  32  controller address
- dat_o  out  16  controller write data
- sel_o  out  2  controller byte selects
- acc_o  out  1  controller access request
- we_o  out  1  controller write enable
- ack_i  in  1  controller ack
- dat_i  in  16  controller read data
- grant_o  out  3  index of the current or last grant (status)
- spurious_ack_o  out  1  sticky flag: ack_i arrived while no port was in BUSY

Behaviour:
- Reset (async, sdram_rst_n=0) forces:
  - state=IDLE, grant_o=0, rr_ptr=0, hold counter=0, spurious_ack_o=0
  - acc_o=0, we_o=0, port_ack_o=0, immediately and without waiting for a clock edge
  - adr_o/dat_o/sel_o follow port 0 (don't-care)
  - Reset mid-access abandons the access; the ports and controller are reset by the same tree.
- States: IDLE, BUSY, HOLD.
- IDLE:
  - acc_o=0 and port_ack_o=0.
  - If any port_acc_i is set, register a winner into grant_o and go to BUSY on the next edge.
  - Round-robin search starts at rr_ptr and takes the first set bit, wrapping from NUM_PORTS-1 to 0.
  - Arbitration latency is exactly 1 cycle: port acc at edge n gives acc_o at cycle n+1.
- BUSY:
  - Combinational muxes driven by grant_o:
    - acc_o = port_acc_i[g]
    - we_o = port_we_i[g]
    - adr_o/dat_o/sel_o = port g fields
    - port_ack_o[g] = ack_i, all other bits 0
  - The muxes must be combinational, with no added register stage, because a port changes adr/dat/sel in the same cycle as ack_i during 16-bit split writes.
  - If port_acc_i[g] falls: go to HOLD with counter=HOLD_CYCLES-1, or straight to IDLE when HOLD_CYCLES=0.
- HOLD:
  - acc_o=0 and port_ack_o=0 while port_acc_i[g]=0.
  - If port_acc_i[g] rises: go to BUSY the same cycle. acc_o follows combinationally with zero extra latency, and other requesters are ignored.
  - Else if counter==0: go to IDLE. Else decrement the counter.
- rr_ptr update: on every HOLD->IDLE or BUSY->IDLE transition, rr_ptr = (grant_o+1) mod NUM_PORTS. It is never updated otherwise.
- port_dat_o = dat_i unconditionally. Ports qualify read data with their ack.
- spurious_ack_o: set when ack_i=1 and state!=BUSY. Cleared only by reset.
- Simultaneous events:
  - Grant port drops acc in the same cycle another port raises acc: the BUSY->HOLD transition wins.
  - All ports requesting: each is served once per NUM_PORTS grants.
  - Non-granted requesters wait indefinitely. There is no timeout.
- Width rules: grant_o is zero-extended to 3 bits. The hold counter is $clog2(HOLD_CYCLES+1) bits wide, minimum 1 bit.

Optional Feature:
- Macro: SDRAM_ARB_FIXED_PRIO_EN
- Defined: IDLE picks the lowest-indexed requesting port, ignoring rr_ptr. rr_ptr is not implemented. Port 0 has the highest priority.
- Undefined: round-robin as above.
- HOLD behaviour is identical in both builds.

Test Plan:
- Port 1 asserts acc, we=1, adr=0x0000_1000; controller acks 2 cycles after acc_o:
  - acc_o rises exactly 1 cycle after port acc.
  - port_ack_o=2'b10 in the ack cycle.
  - adr_o switches to 0x0000_1002 combinationally when the port changes it in the ack cycle.
- Port 0 read, acc drops then re-asserts 2 cycles later, while port 1 requests continuously, HOLD_CYCLES=4:
  - grant_o stays 0 across the gap.
  - Port 1 is granted only after port 0 drops acc for 4 cycles.
- Both ports request continuously, single-ack accesses:
  - Grants alternate 0,1,0,1.
  - With SDRAM_ARB_FIXED_PRIO_EN defined and port 0 re-requesting within HOLD, port 1 never wins while port 0 requests.
- HOLD_CYCLES=0, port 0 drops acc:
  - IDLE on the next edge.
  - A pending port 1 sees acc_o 1 cycle later.
- ack_i pulsed while IDLE:
  - spurious_ack_o=1 and stays set.
  - port_ack_o stays 0.
- sdram_rst_n pulled low mid-BUSY, between clock edges:
  - acc_o=0 and port_ack_o=0 immediately.
  - After release, a port 1 request is granted with grant_o=1 one cycle after the request.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller access interface between NUM_PORTS ports.
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest).
module sdram_port_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                    sdram_clk,
   input  logic                    sdram_rst_n,
   input  logic [NUM_PORTS*32-1:0] port_adr_i,
   input  logic [NUM_PORTS*16-1:0] port_dat_i,
   input  logic [NUM_PORTS*2-1:0]  port_sel_i,
   input  logic [NUM_PORTS-1:0]    port_acc_i,
   input  logic [NUM_PORTS-1:0]    port_we_i,
   output logic [NUM_PORTS-1:0]    port_ack_o,
   output logic [15:0]             port_dat_o,
   output logic [31:0]             adr_o,
   output logic [15:0]             dat_o,
   output logic [1:0]              sel_o,
   output logic                    acc_o,
   output logic                    we_o,
   input  logic                    ack_i,
   input  logic [15:0]             dat_i,
   output logic [2:0]              grant_o,
   output logic                    spurious_ack_o
);
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [GW-1:0] grant_reg, grant_next;
   logic [CW-1:0] hold_cnt_reg, hold_cnt_next;
   logic          spurious_reg, spurious_next;
   logic [GW-1:0] winner;
   logic          any_req;
   logic          grant_acc;
   logic          live;

   assign any_req   = |port_acc_i;
   assign grant_acc = port_acc_i[grant_reg];

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      winner = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_acc_i[i]) winner = GW'(i);
      end
   end
`else
   localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

   logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
   logic [GW-1:0] grant_inc;
   logic          release_grant;

   // Search starts at rr_ptr and wraps, so the port just served goes last.
   always_comb begin
      logic found;
      int   idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = int'(rr_ptr_reg) + i;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && port_acc_i[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end

   assign grant_inc     = (grant_reg == LAST_PORT) ? '0 : grant_reg + 1'b1;
   assign release_grant = (state_reg != IDLE) && (state_next == IDLE);
   assign rr_ptr_next   = release_grant ? grant_inc : rr_ptr_reg;

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) rr_ptr_reg <= '0;
      else              rr_ptr_reg <= rr_ptr_next;
   end
`endif

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         hold_cnt_reg <= '0;
         spurious_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         hold_cnt_reg <= hold_cnt_next;
         spurious_reg <= spurious_next;
      end
   end

   // HOLD keeps the grant across the acc gap between the two bursts of a refill.
   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      hold_cnt_next = hold_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               state_next = BUSY;
               grant_next = winner;
            end
         end
         BUSY: begin
            if (!grant_acc) begin
               if (HOLD_CYCLES == 0) begin
                  state_next = IDLE;
               end else begin
                  state_next    = HOLD;
                  hold_cnt_next = HOLD_INIT;
               end
            end
         end
         HOLD: begin
            if (grant_acc)                 state_next    = BUSY;
            else if (hold_cnt_reg == '0)   state_next    = IDLE;
            else                           hold_cnt_next = hold_cnt_reg - 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign spurious_next = spurious_reg | (ack_i & (state_reg != BUSY));

   // Muxes stay combinational: ports change adr/dat/sel in the ack cycle of split writes.
   always_comb begin
      live  = (state_reg == BUSY) || ((state_reg == HOLD) && grant_acc);
      acc_o = live & grant_acc;
      we_o  = live & port_we_i[grant_reg];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
         assign port_ack_o[gi] = live && (grant_reg == GW'(gi)) && ack_i;
      end
   endgenerate

   assign adr_o          = port_adr_i[grant_reg*32 +: 32];
   assign dat_o          = port_dat_i[grant_reg*16 +: 16];
   assign sel_o          = port_sel_i[grant_reg*2 +: 2];
   assign port_dat_o     = dat_i;
   assign grant_o        = 3'(grant_reg);
   assign spurious_ack_o = spurious_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed stimulus with a scoreboard of acked controller accesses.
// Expectations switch to fixed priority when SDRAM_ARB_FIXED_PRIO_EN is defined.
module tb_sdram_port_arbiter;
   localparam int NP = 2;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic            sdram_clk   = 1'b0;
   logic            sdram_rst_n = 1'b0;
   logic [NP*32-1:0] port_adr = '0;
   logic [NP*16-1:0] port_dat = '0;
   logic [NP*2-1:0]  port_sel = '0;
   logic [NP-1:0]    port_acc = '0;
   logic [NP-1:0]    port_we  = '0;
   logic [NP-1:0]    port_ack;
   logic [15:0]      port_dat_rd, dat_o, dat_in = '0;
   logic [31:0]      adr_o;
   logic [1:0]       sel_o;
   logic             acc_o, we_o, ack_in = 1'b0;
   logic [2:0]       grant;
   logic             spurious;

   logic [NP-1:0]    h0_acc = '0;
   logic [NP-1:0]    h0_port_ack;
   logic [15:0]      h0_port_dat, h0_dat;
   logic [31:0]      h0_adr;
   logic [1:0]       h0_sel;
   logic             h0_acc_o, h0_we, h0_spur;
   logic [2:0]       h0_grant;

   typedef struct {
      int          port;
      logic [31:0] adr;
      logic        we;
      logic [15:0] wdat;
      logic [1:0]  sel;
      logic [15:0] rdat;
   } txn_t;

   txn_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 sdram_clk = ~sdram_clk;

   sdram_port_arbiter #(.NUM_PORTS(NP), .HOLD_CYCLES(4)) dut (
      .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n),
      .port_adr_i(port_adr), .port_dat_i(port_dat), .port_sel_i(port_sel),
      .port_acc_i(port_acc), .port_we_i(port_we), .port_ack_o(port_ack),
      .port_dat_o(port_dat_rd), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
      .acc_o(acc_o), .we_o(we_o), .ack_i(ack_in), .dat_i(dat_in),
      .grant_o(grant), .spurious_ack_o(spurious)
   );

   sdram_port_arbiter #(.NUM_PORTS(NP), .HOLD_CYCLES(0)) dut_h0 (
      .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n),
      .port_adr_i(port_adr), .port_dat_i(port_dat), .port_sel_i(port_sel),
      .port_acc_i(h0_acc), .port_we_i(port_we), .port_ack_o(h0_port_ack),
      .port_dat_o(h0_port_dat), .adr_o(h0_adr), .dat_o(h0_dat), .sel_o(h0_sel),
      .acc_o(h0_acc_o), .we_o(h0_we), .ack_i(1'b0), .dat_i(16'h0000),
      .grant_o(h0_grant), .spurious_ack_o(h0_spur)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge sdram_clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic acc, input logic we, input logic [31:0] adr,
                           input logic [15:0] dat, input logic [1:0] sel);
      port_acc[p]          = acc;
      port_we[p]           = we;
      port_adr[p*32 +: 32] = adr;
      port_dat[p*16 +: 16] = dat;
      port_sel[p*2 +: 2]   = sel;
   endtask

   // Controller acks this cycle; the scoreboard expects the granted port's current fields.
   task automatic expect_ack(input int p, input logic [15:0] rdat);
      txn_t t;
      t.port = p;
      t.adr  = port_adr[p*32 +: 32];
      t.we   = port_we[p];
      t.wdat = port_dat[p*16 +: 16];
      t.sel  = port_sel[p*2 +: 2];
      t.rdat = rdat;
      exp_q.push_back(t);
      ack_in = 1'b1;
      dat_in = rdat;
      $display("txn: port %0d adr 0x%08h we %0d expected ack", p, t.adr, t.we);
   endtask

   task automatic serve_release(input int p);
      expect_ack(p, 16'h0C00 + 16'(p));
      tick();
      ack_in = 1'b0;
      port_acc[p] = 1'b0;
      repeat (5) tick();
      port_acc[p] = 1'b1;
      tick();
      #1;
   endtask

   always @(negedge sdram_clk) begin : monitor
      txn_t t;
      if (sdram_rst_n && acc_o && ack_in) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_ack", 32'(exp_q.size()), 32'd1);
         end else begin
            t = exp_q.pop_front();
            chk("sb_grant",    32'(grant),       32'(t.port));
            chk("sb_port_ack", 32'(port_ack),    32'(1 << t.port));
            chk("sb_adr",      adr_o,            t.adr);
            chk("sb_we",       32'(we_o),        32'(t.we));
            chk("sb_wdat",     32'(dat_o),       32'(t.wdat));
            chk("sb_sel",      32'(sel_o),       32'(t.sel));
            chk("sb_rdat",     32'(port_dat_rd), 32'(t.rdat));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cur, nxt;
      #2;
      chk("rst_acc", 32'(acc_o), 32'd0);
      chk("rst_port_ack", 32'(port_ack), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_spurious", 32'(spurious), 32'd0);
      #10 sdram_rst_n = 1'b1;

      // Port 1 split write: 1-cycle arbitration, adr changes in the ack cycle.
      tick(); set_port(1, 1'b1, 1'b1, 32'h0000_1000, 16'hBEEF, 2'b01); #1;
      chk("t1_idle_acc", 32'(acc_o), 32'd0);
      tick(); #1;
      chk("t1_acc_latency", 32'(acc_o), 32'd1);
      chk("t1_grant", 32'(grant), 32'd1);
      chk("t1_adr_first", adr_o, 32'h0000_1000);
      tick();
      tick(); set_port(1, 1'b1, 1'b1, 32'h0000_1002, 16'h1234, 2'b10); expect_ack(1, 16'h0F0F); #1;
      chk("t1_adr_split", adr_o, 32'h0000_1002);
      chk("t1_port_ack", 32'(port_ack), 32'h2);
      tick(); ack_in = 1'b0; port_acc[1] = 1'b0; port_we[1] = 1'b0;
      repeat (6) tick();

      // Port 0 read with a 2-cycle acc gap while port 1 waits.
      tick();
      set_port(0, 1'b1, 1'b0, 32'h0000_2000, 16'h0000, 2'b11);
      set_port(1, 1'b1, 1'b0, 32'h0000_3000, 16'h0000, 2'b11);
      tick(); #1;
      chk("t2_grant0", 32'(grant), 32'd0);
      chk("t2_acc", 32'(acc_o), 32'd1);
      expect_ack(0, 16'h5A5A); #1;
      chk("t2_port_ack", 32'(port_ack), 32'h1);
      chk("t2_port_dat", 32'(port_dat_rd), 32'h5A5A);
      tick(); ack_in = 1'b0; port_acc[0] = 1'b0;
      tick(); #1;
      chk("t2_hold_acc", 32'(acc_o), 32'd0);
      chk("t2_hold_grant", 32'(grant), 32'd0);
      tick(); port_acc[0] = 1'b1; #1;
      chk("t2_reacq_acc", 32'(acc_o), 32'd1);
      chk("t2_reacq_grant", 32'(grant), 32'd0);
      tick(); expect_ack(0, 16'hA5A5); #1;
      chk("t2_port_ack2", 32'(port_ack), 32'h1);
      tick(); ack_in = 1'b0; port_acc[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         chk("t2_wait_acc", 32'(acc_o), 32'd0);
         chk("t2_wait_grant", 32'(grant), 32'd0);
      end
      tick(); #1;
      chk("t2_grant1", 32'(grant), 32'd1);
      chk("t2_grant1_acc", 32'(acc_o), 32'd1);

      // Both ports requesting, single-ack accesses.
      port_acc[0] = 1'b1;
      cur = 1;
      for (int i = 0; i < 4; i++) begin
         serve_release(cur);
         nxt = FIXED ? 0 : 1 - cur;
         chk("t3_grant", 32'(grant), 32'(nxt));
         chk("t3_acc", 32'(acc_o), 32'd1);
         $display("txn: grant %0d -> %0d", cur, nxt);
         cur = nxt;
      end
      port_acc = '0;
      repeat (7) tick();

      // HOLD_CYCLES=0 instance.
      tick(); h0_acc = 2'b01;
      tick(); #1;
      chk("h0_grant0", 32'(h0_grant), 32'd0);
      chk("h0_busy_acc", 32'(h0_acc_o), 32'd1);
      h0_acc = 2'b11;
      tick(); h0_acc = 2'b10;
      tick(); #1;
      chk("h0_idle_acc", 32'(h0_acc_o), 32'd0);
      chk("h0_idle_grant", 32'(h0_grant), 32'd0);
      tick(); #1;
      chk("h0_grant1", 32'(h0_grant), 32'd1);
      chk("h0_grant1_acc", 32'(h0_acc_o), 32'd1);
      h0_acc = '0;

      // Spurious ack while IDLE.
      tick(); #1;
      chk("t5_spur_before", 32'(spurious), 32'd0);
      ack_in = 1'b1; #1;
      chk("t5_port_ack", 32'(port_ack), 32'd0);
      tick(); ack_in = 1'b0; #1;
      chk("t5_spur_set", 32'(spurious), 32'd1);
      repeat (3) tick();
      chk("t5_spur_sticky", 32'(spurious), 32'd1);

      // Asynchronous reset mid-BUSY.
      tick(); set_port(1, 1'b1, 1'b0, 32'h0000_4000, 16'h0000, 2'b11);
      tick(); #1;
      chk("t6_busy_grant", 32'(grant), 32'd1);
      ack_in = 1'b1; #1;
      sdram_rst_n = 1'b0; #1;
      chk("t6_rst_acc", 32'(acc_o), 32'd0);
      chk("t6_rst_port_ack", 32'(port_ack), 32'd0);
      chk("t6_rst_grant", 32'(grant), 32'd0);
      chk("t6_rst_spur", 32'(spurious), 32'd0);
      ack_in = 1'b0; port_acc = '0;
      tick(); tick(); sdram_rst_n = 1'b1;
      tick(); port_acc[1] = 1'b1; #1;
      chk("t6_req_acc", 32'(acc_o), 32'd0);
      tick(); #1;
      chk("t6_post_grant", 32'(grant), 32'd1);
      chk("t6_post_acc", 32'(acc_o), 32'd1);
      port_acc = '0;
      repeat (2) tick();

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
